consumer_checker: RTL and testbench
===================================

// Module: consumer_checker
// PURPOSE
//  Sink end of the dual-lane pipeline test harness: consumes both pipeline output lanes,
//  checks each against the sequence the producer generates (lane1 0,2,4.., lane2 1,3,5..),
//  and drives stall_1/stall_2 back to the producer as pseudo-random backpressure.
//  Reports pass/error counts, first-mismatch capture and a done flag for the top-level bench.
// PARAMETERS
//  DATA_W        32         lane data width; expected values wrap modulo 2^DATA_W
//  LANE1_SEED    0          first expected value, lane 1
//  LANE2_SEED    1          first expected value, lane 2
//  STEP          2          per-beat increment of expected value, both lanes
//  OFFSET        0          constant the pipeline adds; compare data == expected + OFFSET
//  TARGET_COUNT  1024       beats each lane must check before DONE
//  LFSR_SEED     16'hACE1   stall LFSR reset value, must be non-zero
// PORTS
//  clk                 in   1       single clock, all logic rising-edge
//  reset               in   1       synchronous, active-high
//  start               in   1       level; IDLE->RUN when high
//  stall_en            in   1       0: no random stall in RUN; 1: LFSR-driven stall
//  out_valid           in   2       [0] lane1 beat, [1] lane2 beat
//  pipeline1_outputs   in   DATA_W  lane1 data, qualified by out_valid[0]
//  pipeline2_outputs   in   DATA_W  lane2 data, qualified by out_valid[1]
//  flush_1, flush_2    in   1       producer flush pulses; arm lane resync
//  stall_1, stall_2    out  1       registered backpressure to producer
//  done                out  1       sticky in DONE
//  error               out  1       sticky, set on first mismatch
//  err_count           out  16      mismatch count, saturates at 16'hFFFF
//  pass_count_1/_2     out  32      beats checked per lane (resync beats included)
//  first_err_lane      out  1       0 = lane1, 1 = lane2 (lane1 wins if simultaneous)
//  first_err_exp/_got  out  DATA_W  expected / received value of first mismatch
// BEHAVIOUR
//  - Reset: state IDLE; stall_1=stall_2=1; done=0; error=0; all counts/captures 0;
//    expected regs = SEEDs; LFSR = LFSR_SEED; resync_pending=0. Reset mid-RUN aborts same edge.
//  - FSM: IDLE --start--> RUN --(pass_count_1>=TARGET && pass_count_2>=TARGET)--> DONE.
//    DONE exits only via reset. start ignored outside IDLE.
//  - Stall (registered, 1-cycle latency): IDLE/DONE -> both 1. RUN -> stall_1 <= stall_en & lfsr[0],
//    stall_2 <= stall_en & lfsr[8]; a lane that reached TARGET holds its stall at 1.
//  - LFSR: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, advances every RUN cycle only.
//  - Beats: accepted only in RUN, any cycle out_valid[i]=1, regardless of stall_i (in-flight
//    data after stall is legal). Beats in IDLE/DONE are ignored (no count, no compare).
//  - Compare: match if data == exp_i + OFFSET -> pass_count_i++. Mismatch -> pass_count_i
//    unchanged, err_count++ (sat), error=1, capture if first. exp_i <= exp_i + STEP either way
//    (no resync on mismatch).
//  - Flush: flush_i=1 sets resync_pending_i. Next lane-i beat (same cycle as flush included)
//    is not compared: exp_i <= data - OFFSET + STEP, pass_count_i++, pending cleared.
//  - Both lanes independent; simultaneous beats/errors on both lanes each counted (err_count +2).
//  - Beats past TARGET on a finished lane are still checked until state = DONE.
// STRUCTURE
//  - consumer_pkg: state enum (IDLE/RUN/DONE), LFSR taps, default seeds.
//  - Sub-module lane_checker (x2): exp reg, resync_pending, compare, pass counter, mismatch pulse.
//  - Top: FSM, LFSR, stall regs, err_count saturation, first-error capture/arbitration.
// TESTING
//  1. stall_en=0, identity pipeline, TARGET=16, start -> done=1 after 16 beats/lane, error=0, pass=16/16.
//  2. Corrupt lane2 beat 6 (exp 11, drive 12) -> error=1, err_count=1, lane=1, exp=11, got=12;
//     next beat 13 passes.
//  3. flush_1 pulse, lane1 jumps 0x40 -> 0x80 -> no error; next expected 0x82.
//  4. stall_en=1 -> stall_1/2 match LFSR model bit-for-bit, one cycle late; all beats pass.
//  5. reset asserted mid-RUN -> next cycle IDLE, stall=2'b11, counts 0, expected = seeds.
//  6. Beats with valid in IDLE ignored; force 65536 mismatches -> err_count holds 16'hFFFF.

Source files
------------

// File: rtl/consumer_checker_pkg.sv
// Shared types and constants for the dual-lane consumer/checker.
// Holds the FSM state encoding, the stall LFSR taps and the default seeds.
package consumer_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS      = 16'h002D;
  localparam logic [15:0] DEF_LFSR_SEED  = 16'hACE1;
  localparam int          DEF_LANE1_SEED = 0;
  localparam int          DEF_LANE2_SEED = 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/consumer_checker_if.sv
// Lane data, valids, flush pulses and backpressure between producer pipeline and checker.
interface consumer_checker_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        out_valid;
  logic [DATA_W-1:0] pipeline1_outputs;
  logic [DATA_W-1:0] pipeline2_outputs;
  logic              flush_1;
  logic              flush_2;
  logic              stall_1;
  logic              stall_2;

  modport master (
    output out_valid, pipeline1_outputs, pipeline2_outputs, flush_1, flush_2,
    input  stall_1, stall_2
  );

  modport slave (
    input  out_valid, pipeline1_outputs, pipeline2_outputs, flush_1, flush_2,
    output stall_1, stall_2
  );
endinterface

// File: rtl/consumer_checker_lane_checker.sv
// One lane of the checker: tracks the expected sequence, resyncs after a flush,
// counts checked beats and flags a mismatch combinationally for the top to collect.
module lane_checker #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter logic [DATA_W-1:0] STEP   = DATA_W'(2),
  parameter logic [DATA_W-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              flush,
  output logic [31:0]       pass_count,
  output logic              mismatch,
  output logic [DATA_W-1:0] expected
);

  logic [DATA_W-1:0] exp_q;
  logic              pending_q;
  logic              beat;
  logic              resync;

  assign beat     = en & valid;
  // A flush arriving together with a beat resyncs on that very beat.
  assign resync   = pending_q | flush;
  assign expected = exp_q + OFFSET;
  assign mismatch = beat & ~resync & (data != expected);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q      <= SEED;
      pending_q  <= 1'b0;
      pass_count <= '0;
    end else if (beat) begin
      pending_q <= 1'b0;
      if (resync) begin
        exp_q      <= data - OFFSET + STEP;
        pass_count <= pass_count + 32'd1;
      end else begin
        exp_q <= exp_q + STEP;
        if (!mismatch) pass_count <= pass_count + 32'd1;
      end
    end else if (flush) begin
      pending_q <= 1'b1;
    end
  end

endmodule

// File: rtl/consumer_checker.sv
// Sink of the dual-lane pipeline harness: checks both lanes, drives LFSR backpressure,
// and reports pass/error counts, first-mismatch capture and completion.
module consumer_checker
  import consumer_checker_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] LANE1_SEED   = DATA_W'(DEF_LANE1_SEED),
  parameter logic [DATA_W-1:0] LANE2_SEED   = DATA_W'(DEF_LANE2_SEED),
  parameter logic [DATA_W-1:0] STEP         = DATA_W'(2),
  parameter logic [DATA_W-1:0] OFFSET       = '0,
  parameter int unsigned       TARGET_COUNT = 1024,
  parameter logic [15:0]       LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall_en,
  consumer_checker_if.slave bus,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [31:0]       pass_count_1,
  output logic [31:0]       pass_count_2,
  output logic              first_err_lane,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic              run;
  logic              fin_1, fin_2;
  logic              mm_1, mm_2;
  logic [DATA_W-1:0] exp_1, exp_2;
  logic [16:0]       err_sum;

  assign run   = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign fin_1 = (pass_count_1 >= 32'(TARGET_COUNT));
  assign fin_2 = (pass_count_2 >= 32'(TARGET_COUNT));

  lane_checker #(.DATA_W(DATA_W), .SEED(LANE1_SEED), .STEP(STEP), .OFFSET(OFFSET)) u_lane_1 (
    .clk(clk), .reset(reset), .en(run), .valid(bus.out_valid[0]),
    .data(bus.pipeline1_outputs), .flush(bus.flush_1),
    .pass_count(pass_count_1), .mismatch(mm_1), .expected(exp_1)
  );

  lane_checker #(.DATA_W(DATA_W), .SEED(LANE2_SEED), .STEP(STEP), .OFFSET(OFFSET)) u_lane_2 (
    .clk(clk), .reset(reset), .en(run), .valid(bus.out_valid[1]),
    .data(bus.pipeline2_outputs), .flush(bus.flush_2),
    .pass_count(pass_count_2), .mismatch(mm_2), .expected(exp_2)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default the combinational output first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (fin_1 && fin_2) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Backpressure: a finished lane stays stalled; the LFSR only advances while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q      <= LFSR_SEED;
      bus.stall_1 <= 1'b1;
      bus.stall_2 <= 1'b1;
    end else if (run) begin
      lfsr_q      <= lfsr_next(lfsr_q);
      bus.stall_1 <= fin_1 | (stall_en & lfsr_q[0]);
      bus.stall_2 <= fin_2 | (stall_en & lfsr_q[8]);
    end else begin
      bus.stall_1 <= 1'b1;
      bus.stall_2 <= 1'b1;
    end
  end

  assign err_sum = {1'b0, err_count} + 17'(mm_1) + 17'(mm_2);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count      <= '0;
      error          <= 1'b0;
      first_err_lane <= 1'b0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (!error && (mm_1 || mm_2)) begin
        error          <= 1'b1;
        first_err_lane <= ~mm_1;
        first_err_exp  <= mm_1 ? exp_1 : exp_2;
        first_err_got  <= mm_1 ? bus.pipeline1_outputs : bus.pipeline2_outputs;
      end
    end
  end

endmodule

// File: tb/tb_consumer_checker.sv
// Scoreboarded random bench for consumer_checker: a behavioural model predicts the status
// after every clock, and a monitor compares it against the DUT one step behind the driver.
module tb_consumer_checker;

  localparam int          DW   = 32;
  localparam int          TGT  = 16;
  localparam logic [31:0] STP  = 32'd2;
  localparam logic [31:0] OFS  = 32'd0;
  localparam logic [15:0] LSEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall_en = 1'b0;
  logic        done, error, first_err_lane;
  logic [15:0] err_count;
  logic [31:0] pass_count_1, pass_count_2, first_err_exp, first_err_got;

  always #5 clk = ~clk;

  consumer_checker_if #(.DATA_W(DW)) bus ();

  consumer_checker #(
    .DATA_W(DW), .LANE1_SEED(32'd0), .LANE2_SEED(32'd1), .STEP(STP), .OFFSET(OFS),
    .TARGET_COUNT(TGT), .LFSR_SEED(LSEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall_en(stall_en), .bus(bus),
    .done(done), .error(error), .err_count(err_count),
    .pass_count_1(pass_count_1), .pass_count_2(pass_count_2),
    .first_err_lane(first_err_lane), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  typedef struct {
    logic [31:0] p1, p2;
    logic [15:0] ec;
    logic        er, dn, ln, s1, s2;
    logic [31:0] fe, fg;
  } snap_t;

  snap_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: what the checker should report after each edge.
  int          m_state;          // 0 idle, 1 checking, 2 finished
  logic [31:0] m_exp [2];        // next value each lane should carry
  bit          m_pend[2];
  logic [31:0] m_pc  [2];
  int          m_ec;
  bit          m_err, m_ln, m_st[2];
  logic [31:0] m_fe, m_fg;
  logic [15:0] m_lfsr;

  task automatic model_step(input bit rst, input bit st, input bit sen, input logic [1:0] v,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input bit f1, input bit f2);
    logic [31:0] d[2];
    bit          f[2], fin[2], run, b;
    snap_t       s;
    d[0] = d1; d[1] = d2; f[0] = f1; f[1] = f2;
    if (rst) begin
      m_state = 0; m_exp[0] = 0; m_exp[1] = 1; m_pend = '{0, 0}; m_pc = '{0, 0};
      m_ec = 0; m_err = 0; m_ln = 0; m_fe = 0; m_fg = 0; m_lfsr = LSEED; m_st = '{1, 1};
    end else begin
      run = (m_state == 1);
      for (int i = 0; i < 2; i++) fin[i] = (m_pc[i] >= TGT);
      for (int i = 0; i < 2; i++) begin
        if (run && v[i]) begin
          if (m_pend[i] || f[i]) begin
            m_exp[i] = d[i] - OFS + STP;
            m_pc[i]++;
          end else if (d[i] == m_exp[i] + OFS) begin
            m_exp[i] += STP;
            m_pc[i]++;
          end else begin
            if (!m_err) begin
              m_err = 1; m_ln = (i == 1); m_fe = m_exp[i] + OFS; m_fg = d[i];
            end
            m_ec = (m_ec + 1 > 65535) ? 65535 : m_ec + 1;
            m_exp[i] += STP;
          end
          m_pend[i] = 0;
        end else if (f[i]) begin
          m_pend[i] = 1;
        end
      end
      if (run) begin
        m_st[0] = fin[0] || (sen && m_lfsr[0]);
        m_st[1] = fin[1] || (sen && m_lfsr[8]);
        b = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = (m_lfsr >> 1) | (16'(b) << 15);
      end else begin
        m_st = '{1, 1};
      end
      if (m_state == 0 && st) m_state = 1;
      else if (run && fin[0] && fin[1]) m_state = 2;
    end
    s.p1 = m_pc[0]; s.p2 = m_pc[1]; s.ec = 16'(m_ec); s.er = m_err; s.dn = (m_state == 2);
    s.ln = m_ln; s.fe = m_fe; s.fg = m_fg; s.s1 = m_st[0]; s.s2 = m_st[1];
    sb_q.push_back(s);
  endtask

  // Drive one cycle of stimulus on the falling edge and record the prediction.
  task automatic cyc(input bit rst, input bit st, input bit sen, input logic [1:0] v,
                     input logic [31:0] d1, input logic [31:0] d2, input bit f1, input bit f2);
    @(negedge clk);
    reset = rst; start = st; stall_en = sen;
    bus.out_valid = v; bus.pipeline1_outputs = d1; bus.pipeline2_outputs = d2;
    bus.flush_1 = f1; bus.flush_2 = f2;
    model_step(rst, st, sen, v, d1, d2, f1, f2);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  snap_t e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pass_count_1", pass_count_1, e.p1);
        check("pass_count_2", pass_count_2, e.p2);
        check("err_count", err_count, e.ec);
        check("error", error, e.er);
        check("done", done, e.dn);
        check("first_err_lane", first_err_lane, e.ln);
        check("first_err_exp", first_err_exp, e.fe);
        check("first_err_got", first_err_got, e.fg);
        check("stall_1", bus.stall_1, e.s1);
        check("stall_2", bus.stall_2, e.s2);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] prod1, prod2, d1, d2;
  logic [1:0]  v;
  bit          f1, f2, fl1_done, fl2_done, bad_done;

  initial begin
    bus.out_valid = 2'b00; bus.pipeline1_outputs = '0; bus.pipeline2_outputs = '0;
    bus.flush_1 = 1'b0; bus.flush_2 = 1'b0;

    // Phase A: reset, beats in IDLE ignored, clean run without random stall.
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 2'b11, $urandom, $urandom, 0, 0);
    settle();
    check("idle_pass_1", pass_count_1, 0);
    check("idle_stalls", {bus.stall_2, bus.stall_1}, 2'b11);
    cyc(0, 1, 0, 2'b00, 0, 0, 0, 0);
    prod1 = 0; prod2 = 1;
    for (int c = 0; c < 400 && m_state != 2; c++) begin
      v = 2'($urandom_range(0, 3));
      cyc(0, 0, 0, v, prod1, prod2, 0, 0);
      if (v[0]) prod1 += 2;
      if (v[1]) prod2 += 2;
    end
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 0);
    settle();
    check("A_done", done, 1);
    check("A_error", error, 0);
    check("A_pass1_reached", pass_count_1 >= TGT, 1);
    check("A_pass2_reached", pass_count_2 >= TGT, 1);
    repeat (3) cyc(0, 1, 0, 2'b11, 32'hBAD0, 32'hBAD1, 0, 0);
    settle();
    check("A_done_beats_ignored", err_count, 0);

    // Phase B: random stall, lane2 corruption, flush with and without a same-cycle beat.
    cyc(1, 0, 1, 2'b00, 0, 0, 0, 0);
    cyc(0, 1, 1, 2'b00, 0, 0, 0, 0);
    prod1 = 0; prod2 = 1; fl1_done = 0; fl2_done = 0; bad_done = 0;
    for (int c = 0; c < 600 && m_state != 2; c++) begin
      v = 2'($urandom_range(0, 3));
      f1 = 0; f2 = 0; d1 = prod1; d2 = prod2;
      if (v[0] && prod1 == 32'h10 && !fl1_done) begin
        f1 = 1; d1 = 32'h80; prod1 = 32'h80; fl1_done = 1;
      end
      if (v[1] && prod2 == 32'd11 && !bad_done) begin
        d2 = 32'd12; bad_done = 1;
      end
      if (prod2 == 32'd21 && !fl2_done) begin
        v[1] = 0; f2 = 1; prod2 = 32'h101; fl2_done = 1;
      end
      cyc(0, 0, 1, v, d1, d2, f1, f2);
      if (v[0]) prod1 += 2;
      if (v[1]) prod2 += 2;
    end
    settle();
    check("B_done", done, 1);
    check("B_error", error, 1);
    check("B_err_count", err_count, 1);
    check("B_first_lane", first_err_lane, 1);
    check("B_first_exp", first_err_exp, 11);
    check("B_first_got", first_err_got, 12);

    // Phase C: reset in the middle of a run.
    cyc(1, 0, 1, 2'b00, 0, 0, 0, 0);
    cyc(0, 1, 1, 2'b00, 0, 0, 0, 0);
    prod1 = 0; prod2 = 1;
    repeat (6) begin
      cyc(0, 0, 1, 2'b11, prod1, prod2 + 1, 0, 0);
      prod1 += 2; prod2 += 2;
    end
    cyc(1, 0, 1, 2'b11, prod1, prod2, 0, 0);
    settle();
    check("C_pass_1", pass_count_1, 0);
    check("C_err_count", err_count, 0);
    check("C_stalls", {bus.stall_2, bus.stall_1}, 2'b11);
    cyc(0, 1, 0, 2'b00, 0, 0, 0, 0);
    cyc(0, 0, 0, 2'b11, 32'd0, 32'd1, 0, 0);
    settle();
    check("C_seed_restart", {pass_count_2, pass_count_1}, {32'd1, 32'd1});

    // Phase D: both lanes mismatch every cycle until the error count saturates.
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc(0, 1, 0, 2'b00, 0, 0, 0, 0);
    prod1 = 0; prod2 = 1;
    for (int c = 0; c < 32770; c++) begin
      cyc(0, 0, 0, 2'b11, prod1 + 1, prod2 + 1, 0, 0);
      prod1 += 2; prod2 += 2;
    end
    settle();
    check("D_err_saturated", err_count, 16'hFFFF);
    check("D_first_lane", first_err_lane, 0);
    check("D_first_exp", first_err_exp, 0);
    check("D_first_got", first_err_got, 1);

    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
